pc_branch_aluctl: RTL and testbench
===================================

Name: pc_branch_aluctl

Overview:
- Instruction-sequencing support block of the single-cycle MIPS core.
- Holds the program-counter register (advanced once per instruction phase cycle), computes the branch-taken qualifier (branch AND zero), and decodes the 4-bit ALU control code from the main-control ALUOp and the R-type funct field.
- PC register is the only sequential element; branch qualifier and ALU-control decode are purely combinational.

Parameters:
- ADDR_W, 32, width of PC address.
- RESET_ADDR, 32'h0000_0000, PC value after reset.
- LOAD_PHASE, 4'd9, value of cont at which the PC loads the next address.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- cont  input  4  instruction phase counter (0..9, wraps to 0).
- end_entrada  input  ADDR_W  next-PC value from the next-PC mux.
- end_saida  output  ADDR_W  current PC; registered.
- branch  input  1  branch control from main control.
- zero  input  1  ALU zero flag.
- and_branch  output  1  branch-taken select for the next-PC mux.
- aluop  input  2  ALUOp from main control.
- funct  input  6  instruction bits [5:0].
- controle_ula  output  4  ALU operation code.

Behaviour:
- PC register:
  - At rising clk: if reset=1, end_saida <= RESET_ADDR, regardless of cont.
  - Otherwise, if cont == LOAD_PHASE, end_saida <= end_entrada.
  - Otherwise end_saida holds.
- cont values 10..15 never match the default LOAD_PHASE, so the PC holds; no error flag.
- PC update latency: one clock edge after cont == LOAD_PHASE is sampled.
- Exactly one PC update per 10-phase instruction cycle when cont sweeps 0..9.
- Reset mid-phase (any cont) forces RESET_ADDR on that edge.
- Reset has priority over load.
- No wrap or overflow checking: end_entrada is loaded verbatim (e.g. 32'hFFFF_FFFC is legal).
- and_branch = branch & zero, combinational, no reset dependence.
- controle_ula, combinational, fully decoded, no latch:
  - aluop=00 -> 0010 (add; lw/sw).
  - aluop=01 -> 0110 (sub; beq).
  - aluop=10, decoded from funct:
    - 100000 -> 0010 (add)
    - 100010 -> 0110 (sub)
    - 100100 -> 0000 (and)
    - 100101 -> 0001 (or)
    - 101010 -> 0111 (slt)
    - 100111 -> 1100 (nor)
    - any other funct -> 1111 (invalid; the ALU must treat it as a no-op/zero result).
  - aluop=11 -> 1111 (invalid), funct ignored.
- controle_ula and and_branch are unaffected by reset and clk; they follow their inputs within the same cycle.
- X on funct while aluop is 00 or 01 must not propagate to controle_ula.

Test Plan:
- Reset: reset=1 for one edge with cont=5 and end_entrada=32'h40 -> end_saida=0. Release reset and hold cont=3 for 3 edges -> end_saida stays 0.
- PC advance: cont cycles 0..9 repeatedly, end_entrada driven to end_saida+4 -> end_saida goes 0, 4, 8, with exactly one increment per 10-edge cycle, each increment on the edge where cont=9.
- Reset priority: cont=9, end_entrada=32'h100, reset=1 -> end_saida=0. Next sweep with reset=0 -> 32'h100 loaded at cont=9.
- Branch qualifier: all four (branch, zero) combinations -> and_branch=1 only for (1,1). No clock needed.
- ALU control sweep:
  - aluop 00 with funct=6'bxxxxxx -> 0010.
  - aluop 01 -> 0110.
  - aluop 10 with funct 20/22/24/25/2A/27 hex -> 0010/0110/0000/0001/0111/1100.
  - aluop 10 with funct 6'h08 -> 1111.
  - aluop 11 -> 1111.
- Boundary: end_entrada=32'hFFFF_FFFC loaded at cont=9 -> end_saida=32'hFFFF_FFFC. Then cont=12 with end_entrada=0 -> end_saida holds 32'hFFFF_FFFC.

Source files
------------

// File: rtl/pc_branch_aluctl.sv
// Instruction-sequencing support for the single-cycle MIPS core: PC register,
// branch-taken qualifier and ALU-control decode.
module pc_branch_aluctl #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [3:0]        LOAD_PHASE = 4'd9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cont,
  input  logic [ADDR_W-1:0] end_entrada,
  output logic [ADDR_W-1:0] end_saida,
  input  logic              branch,
  input  logic              zero,
  output logic              and_branch,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic [3:0]        controle_ula
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // aluop is resolved first so funct never reaches the output for 00/01.
  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = 4'b1111;
    case (op)
      2'b00: code = 4'b0010;
      2'b01: code = 4'b0110;
      2'b10: begin
        case (fn)
          6'b100000: code = 4'b0010;
          6'b100010: code = 4'b0110;
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b101010: code = 4'b0111;
          6'b100111: code = 4'b1100;
          default:   code = 4'b1111;
        endcase
      end
      default: code = 4'b1111;
    endcase
    return code;
  endfunction

  always_comb begin
    pc_d = pc_q;
    if (cont == LOAD_PHASE) pc_d = end_entrada;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_ADDR;
    else       pc_q <= pc_d;
  end

  assign end_saida    = pc_q;
  assign and_branch   = branch & zero;
  assign controle_ula = alu_decode(aluop, funct);

endmodule

// File: tb/tb_pc_branch_aluctl.sv
// Directed bench for pc_branch_aluctl: decode/qualifier table plus PC sequences.
module tb_pc_branch_aluctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cont;
  logic [31:0] end_entrada;
  logic [31:0] end_saida;
  logic        branch;
  logic        zero;
  logic        and_branch;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [3:0]  controle_ula;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic       branch;
    logic       zero;
    logic [3:0] exp_ctl;
    logic       exp_and;
  } vec_t;

  vec_t vecs [12];

  pc_branch_aluctl dut (
    .clk          (clk),
    .reset        (reset),
    .cont         (cont),
    .end_entrada  (end_entrada),
    .end_saida    (end_saida),
    .branch       (branch),
    .zero         (zero),
    .and_branch   (and_branch),
    .aluop        (aluop),
    .funct        (funct),
    .controle_ula (controle_ula)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc_exp;

    vecs[0]  = '{2'b00, 6'bxxxxxx, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[1]  = '{2'b01, 6'b100010, 1'b0, 1'b1, 4'b0110, 1'b0};
    vecs[2]  = '{2'b10, 6'h20,     1'b1, 1'b0, 4'b0010, 1'b0};
    vecs[3]  = '{2'b10, 6'h22,     1'b1, 1'b1, 4'b0110, 1'b1};
    vecs[4]  = '{2'b10, 6'h24,     1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{2'b10, 6'h25,     1'b0, 1'b1, 4'b0001, 1'b0};
    vecs[6]  = '{2'b10, 6'h2A,     1'b1, 1'b0, 4'b0111, 1'b0};
    vecs[7]  = '{2'b10, 6'h27,     1'b1, 1'b1, 4'b1100, 1'b1};
    vecs[8]  = '{2'b10, 6'h08,     1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[9]  = '{2'b11, 6'h20,     1'b0, 1'b1, 4'b1111, 1'b0};
    vecs[10] = '{2'b01, 6'bxxxxxx, 1'b1, 1'b1, 4'b0110, 1'b1};
    vecs[11] = '{2'b10, 6'h00,     1'b1, 1'b0, 4'b1111, 1'b0};

    reset = 1'b0; cont = 4'd0; end_entrada = '0;
    branch = 1'b0; zero = 1'b0; aluop = 2'b00; funct = 6'h00;

    // Combinational table; no clock dependence.
    for (int i = 0; i < 12; i++) begin
      aluop  = vecs[i].aluop;
      funct  = vecs[i].funct;
      branch = vecs[i].branch;
      zero   = vecs[i].zero;
      #2;
      chk($sformatf("controle_ula[%0d]", i), {28'h0, controle_ula}, {28'h0, vecs[i].exp_ctl});
      chk($sformatf("and_branch[%0d]", i), {31'h0, and_branch}, {31'h0, vecs[i].exp_and});
    end

    // Reset with a non-load phase, then hold.
    @(negedge clk);
    reset = 1'b1; cont = 4'd5; end_entrada = 32'h40;
    tick();
    chk("reset_value", end_saida, 32'h0);
    reset = 1'b0; cont = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_after_reset", end_saida, 32'h0);
    end

    // Three full phase sweeps, one +4 per sweep on the cont==9 edge.
    pc_exp = 32'h0;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 10; c++) begin
        cont = c[3:0];
        end_entrada = pc_exp + 32'd4;
        tick();
        if (c == 9) pc_exp = pc_exp + 32'd4;
        chk($sformatf("advance s%0d c%0d", s, c), end_saida, pc_exp);
      end
    end

    // Reset beats load on the same edge.
    cont = 4'd9; end_entrada = 32'h100; reset = 1'b1;
    tick();
    chk("reset_priority", end_saida, 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cont = c[3:0];
      tick();
      chk($sformatf("reload c%0d", c), end_saida, (c == 9) ? 32'h100 : 32'h0);
    end

    // Top-of-range address loads verbatim; out-of-range phases hold.
    cont = 4'd9; end_entrada = 32'hFFFF_FFFC;
    tick();
    chk("load_max", end_saida, 32'hFFFF_FFFC);
    end_entrada = 32'h0;
    for (int c = 10; c < 16; c++) begin
      cont = c[3:0];
      tick();
      chk($sformatf("hold_cont%0d", c), end_saida, 32'hFFFF_FFFC);
    end

    // Reset mid-phase clears regardless of cont.
    cont = 4'd6; reset = 1'b1;
    tick();
    chk("reset_midphase", end_saida, 32'h0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
